// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared definitions for the branch resolve unit:
//   - RISC-V conditional-branch func3 encodings
//   - op_kind_e, which selects how the branch/jump target is formed
// The packed result struct depends on XLEN, so each module that holds
// results declares it locally from these definitions.
// ---------------------------------------------------------------------------
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Selects where the taken-path target comes from.
    typedef enum logic [1:0] {
        OP_BRANCH = 2'd0,
        OP_JAL    = 2'd1,
        OP_JALR   = 2'd2
    } op_kind_e;

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluator.
// Ports:
//   func3   in  3     branch type (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   op1     in  XLEN  first compare operand
//   op2     in  XLEN  second compare operand
//   jal     in  1     unconditional PC-relative jump
//   jalr    in  1     unconditional register-indirect jump
//   taken   out 1     resolved direction
//   illegal out 1     func3 010/011 on a non-jump op
// ---------------------------------------------------------------------------
module branch_cond_eval
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            jal,
    input  logic            jalr,
    output logic            taken,
    output logic            illegal
);

    // Jumps are always taken and ignore func3. For conditional branches
    // the compare runs at full XLEN: signed for BLT/BGE, unsigned for
    // BLTU/BGEU. The two unused encodings (010/011) are reported as illegal
    // and resolve not-taken so they fall through.
    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        if (jal || jalr) begin
            taken = 1'b1;
        end else begin
            case (func3)
                F3_BEQ:  taken = (op1 == op2);
                F3_BNE:  taken = (op1 != op2);
                F3_BLT:  taken = ($signed(op1) <  $signed(op2));
                F3_BGE:  taken = ($signed(op1) >= $signed(op2));
                F3_BLTU: taken = (op1 <  op2);
                F3_BGEU: taken = (op1 >= op2);
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit
// Pipelined branch/jump resolver. It evaluates the condition, forms the
// target, checks it against the front-end prediction and presents the
// result through a 2-entry skid buffer (output entry + skid entry).
// Ports:
//   clk, rst_n                 clock (rising edge), synchronous active-low reset
//   flush_i                    drop held and incoming ops
//   in_valid / in_ready        upstream handshake (in_ready is registered)
//   in_func3, in_jal, in_jalr  op type
//   in_op1, in_op2             compare operands (op1 is the JALR base)
//   in_pc, in_imm              instruction PC and sign-extended offset
//   in_pred_taken/target       front-end prediction
//   out_valid / out_ready      downstream handshake
//   out_taken, out_mispredict,
//   out_redirect_pc,
//   out_illegal                resolved result
//   branch_cnt, mispred_cnt    saturating retirement counters
// ---------------------------------------------------------------------------
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int CNT_W      = 32,
    parameter int INST_BYTES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_func3,
    input  logic             in_jal,
    input  logic             in_jalr,
    input  logic [XLEN-1:0]  in_op1,
    input  logic [XLEN-1:0]  in_op2,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic             in_pred_taken,
    input  logic [XLEN-1:0]  in_pred_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_taken,
    output logic             out_mispredict,
    output logic [XLEN-1:0]  out_redirect_pc,
    output logic             out_illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    typedef struct packed {
        logic            taken;
        logic            mispredict;
        logic            illegal;
        logic [XLEN-1:0] redirect_pc;
    } result_t;

    logic            cond_taken;
    logic            cond_illegal;
    op_kind_e        op_kind;
    logic [XLEN-1:0] pc_imm_sum;
    logic [XLEN-1:0] op1_imm_sum;
    logic [XLEN-1:0] fall_through;
    logic [XLEN-1:0] target;
    result_t         new_res;

    result_t         out_res;
    result_t         skid_res;
    logic            out_valid_q;
    logic            skid_valid;
    logic            accept;
    logic            drain;

    branch_cond_eval #(
        .XLEN (XLEN)
    ) u_cond_eval (
        .func3   (in_func3),
        .op1     (in_op1),
        .op2     (in_op2),
        .jal     (in_jal),
        .jalr    (in_jalr),
        .taken   (cond_taken),
        .illegal (cond_illegal)
    );

    // Classify the incoming op; JALR takes precedence when both jump
    // flags are set.
    always_comb begin
        op_kind = OP_BRANCH;
        if (in_jalr) begin
            op_kind = OP_JALR;
        end else if (in_jal) begin
            op_kind = OP_JAL;
        end
    end

    // Target arithmetic wraps modulo 2^XLEN. JALR clears bit 0 of the sum.
    // The redirect PC is always the correct next PC, so downstream can use
    // it whether or not a mispredict is flagged.
    always_comb begin
        pc_imm_sum   = in_pc + in_imm;
        op1_imm_sum  = in_op1 + in_imm;
        fall_through = in_pc + XLEN'(INST_BYTES);
        case (op_kind)
            OP_JALR: target = {op1_imm_sum[XLEN-1:1], 1'b0};
            default: target = pc_imm_sum;
        endcase
        new_res.taken       = cond_taken;
        new_res.illegal     = cond_illegal;
        new_res.mispredict  = (cond_taken != in_pred_taken) ||
                              (cond_taken && (in_pred_target != target));
        new_res.redirect_pc = cond_taken ? target : fall_through;
    end

    // in_ready only depends on the registered skid flag, so neither
    // in_* nor out_ready reach it combinationally.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && !skid_valid;
    assign drain    = out_valid_q && out_ready;

    // Skid buffer. The output entry reloads whenever it is empty or being
    // drained; it takes the skid entry first so ordering is preserved.
    // A new op only lands in the skid entry when the output entry is
    // stalled, which then deasserts in_ready on the next cycle. A flush
    // drops both entries and any op offered in the same cycle; the output
    // data registers are left as-is since out_valid qualifies them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
            out_res     <= '0;
            skid_res    <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
            skid_valid  <= 1'b0;
        end else if (!out_valid_q || out_ready) begin
            if (skid_valid) begin
                out_res     <= skid_res;
                out_valid_q <= 1'b1;
                skid_valid  <= 1'b0;
            end else if (in_valid) begin
                out_res     <= new_res;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_res   <= new_res;
            skid_valid <= 1'b1;
        end
    end

    // Retirement counters. They advance on an output handshake, including
    // one that happens in a flush cycle, and saturate at all-ones. Illegal
    // ops retire without being counted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (drain && !out_res.illegal) begin
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (out_res.mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

    assign out_valid       = out_valid_q;
    assign out_taken       = out_res.taken;
    assign out_mispredict  = out_res.mispredict;
    assign out_illegal     = out_res.illegal;
    assign out_redirect_pc = out_res.redirect_pc;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// tb_branch_resolve_unit
// Self-checking bench for branch_resolve_unit (XLEN=32, CNT_W=4 so that
// counter saturation is reachable). The reference model is a FIFO of
// expected results with capacity 2, plus two saturating integer counters.
// ---------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam int XLEN       = 32;
    localparam int CNT_W      = 4;
    localparam int INST_BYTES = 4;
    localparam int CNT_MAX    = (1 << CNT_W) - 1;

    typedef struct {
        logic            taken;
        logic            mispredict;
        logic            illegal;
        logic [XLEN-1:0] redirect_pc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             flush_i;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_func3;
    logic             in_jal;
    logic             in_jalr;
    logic [XLEN-1:0]  in_op1;
    logic [XLEN-1:0]  in_op2;
    logic [XLEN-1:0]  in_pc;
    logic [XLEN-1:0]  in_imm;
    logic             in_pred_taken;
    logic [XLEN-1:0]  in_pred_target;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic             out_mispredict;
    logic [XLEN-1:0]  out_redirect_pc;
    logic             out_illegal;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    exp_t model_q[$];
    int   model_branch;
    int   model_mispred;
    int   compared;
    int   mismatched;

    branch_resolve_unit #(
        .XLEN       (XLEN),
        .CNT_W      (CNT_W),
        .INST_BYTES (INST_BYTES)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .flush_i         (flush_i),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_func3        (in_func3),
        .in_jal          (in_jal),
        .in_jalr         (in_jalr),
        .in_op1          (in_op1),
        .in_op2          (in_op2),
        .in_pc           (in_pc),
        .in_imm          (in_imm),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_taken       (out_taken),
        .out_mispredict  (out_mispredict),
        .out_redirect_pc (out_redirect_pc),
        .out_illegal     (out_illegal),
        .branch_cnt      (branch_cnt),
        .mispred_cnt     (mispred_cnt)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected result of the op currently on the in_* inputs, computed
    // straight from the ISA rules.
    function automatic exp_t refResult();
        exp_t            r;
        logic [XLEN-1:0] tgt;
        logic [XLEN-1:0] sum;
        r.illegal = 1'b0;
        if (in_jal || in_jalr) begin
            r.taken = 1'b1;
        end else begin
            case (in_func3)
                3'd0:    r.taken = (in_op1 == in_op2);
                3'd1:    r.taken = (in_op1 != in_op2);
                3'd4:    r.taken = ($signed(in_op1) <  $signed(in_op2));
                3'd5:    r.taken = ($signed(in_op1) >= $signed(in_op2));
                3'd6:    r.taken = (in_op1 <  in_op2);
                3'd7:    r.taken = (in_op1 >= in_op2);
                default: begin
                    r.taken   = 1'b0;
                    r.illegal = 1'b1;
                end
            endcase
        end
        if (in_jalr) begin
            sum = in_op1 + in_imm;
            tgt = sum & ~32'h1;
        end else begin
            tgt = in_pc + in_imm;
        end
        r.mispredict  = (r.taken != in_pred_taken) || (r.taken && (in_pred_target != tgt));
        r.redirect_pc = r.taken ? tgt : in_pc + 32'(INST_BYTES);
        return r;
    endfunction

    // One counted comparison.
    task automatic checkValue(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load the op fields onto the inputs (valid is driven by applyStimulus).
    task automatic setOp(input logic [2:0] f3, input logic jal, input logic jalr,
                         input logic [XLEN-1:0] op1, input logic [XLEN-1:0] op2,
                         input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                         input logic pt, input logic [XLEN-1:0] ptgt);
        in_func3       = f3;
        in_jal         = jal;
        in_jalr        = jalr;
        in_op1         = op1;
        in_op2         = op2;
        in_pc          = pc;
        in_imm         = imm;
        in_pred_taken  = pt;
        in_pred_target = ptgt;
    endtask

    // Drive one cycle of control inputs, advance the model across the
    // coming rising edge, then step to the following falling edge.
    task automatic applyStimulus(input logic rst_v, input logic flush_v,
                                 input logic valid_v, input logic oready_v);
        exp_t head;
        bit   room;
        rst_n     = rst_v;
        flush_i   = flush_v;
        in_valid  = valid_v;
        out_ready = oready_v;
        if (!rst_v) begin
            model_q.delete();
            model_branch  = 0;
            model_mispred = 0;
        end else begin
            room = (model_q.size() < 2);
            if (model_q.size() > 0 && oready_v) begin
                head = model_q.pop_front();
                if (!head.illegal) begin
                    if (model_branch < CNT_MAX) model_branch++;
                    if (head.mispredict && model_mispred < CNT_MAX) model_mispred++;
                end
            end
            if (flush_v) begin
                model_q.delete();
            end else if (valid_v && room) begin
                model_q.push_back(refResult());
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare the DUT's visible state with the model.
    task automatic checkOutput(input string tag);
        checkValue({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
        checkValue({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            checkValue({tag, ".taken"}, 32'(out_taken), 32'(model_q[0].taken));
            checkValue({tag, ".mispredict"}, 32'(out_mispredict), 32'(model_q[0].mispredict));
            checkValue({tag, ".illegal"}, 32'(out_illegal), 32'(model_q[0].illegal));
            checkValue({tag, ".redirect_pc"}, out_redirect_pc, model_q[0].redirect_pc);
        end
        checkValue({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(model_branch));
        checkValue({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(model_mispred));
    endtask

    initial begin
        logic [XLEN-1:0] r_op1;
        logic [XLEN-1:0] r_pc;
        logic [XLEN-1:0] r_imm;
        logic            r_rst;
        logic            r_flush;

        compared      = 0;
        mismatched    = 0;
        model_branch  = 0;
        model_mispred = 0;
        rst_n     = 1'b0;
        flush_i   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        setOp(3'd0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, '0);
        $display("[TB] start");

        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("reset");
        checkValue("reset.out_taken", 32'(out_taken), 32'd0);
        checkValue("reset.out_redirect_pc", out_redirect_pc, 32'd0);

        // Operand compares, one op per cycle with out_ready high.
        setOp(3'b100, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h8, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("blt");
        checkValue("blt.taken_const", 32'(out_taken), 32'd1);
        setOp(3'b110, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h8, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("bltu");
        checkValue("bltu.taken_const", 32'(out_taken), 32'd0);
        setOp(3'b111, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000, 32'h40, 32'h8, 1'b1, 32'h48);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("bgeu");
        checkValue("bgeu.taken_const", 32'(out_taken), 32'd1);

        // Prediction check: wrong target, then correct target.
        setOp(3'b000, 1'b0, 1'b0, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 32'h124);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("beq_badtgt");
        checkValue("beq_badtgt.mis_const", 32'(out_mispredict), 32'd1);
        checkValue("beq_badtgt.pc_const", out_redirect_pc, 32'h120);
        setOp(3'b000, 1'b0, 1'b0, 32'h5, 32'h5, 32'h100, 32'h20, 1'b1, 32'h120);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("beq_goodtgt");
        checkValue("beq_goodtgt.mis_const", 32'(out_mispredict), 32'd0);

        // JALR bit-0 clearing and JAL wrap-around; last op has both flags.
        setOp(3'b000, 1'b0, 1'b1, 32'h1001, 32'h0, 32'h200, 32'h4, 1'b1, 32'h1004);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("jalr");
        checkValue("jalr.pc_const", out_redirect_pc, 32'h1004);
        setOp(3'b000, 1'b1, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h10, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("jal_wrap");
        checkValue("jal_wrap.pc_const", out_redirect_pc, 32'h8);
        setOp(3'b000, 1'b1, 1'b1, 32'h3000, 32'h0, 32'h500, 32'h10, 1'b1, 32'h3010);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("jal_jalr");
        checkValue("jal_jalr.pc_const", out_redirect_pc, 32'h3010);

        // Illegal func3: no count on retirement.
        setOp(3'b010, 1'b0, 1'b0, 32'h1, 32'h1, 32'h600, 32'h10, 1'b1, 32'h610);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("illegal");
        checkValue("illegal.ill_const", 32'(out_illegal), 32'd1);
        checkValue("illegal.taken_const", 32'(out_taken), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("illegal_drain");

        // Backpressure: three back-to-back ops while out_ready is low.
        for (int i = 0; i < 3; i++) begin
            setOp(3'b001, 1'b0, 1'b0, 32'h1, 32'h2, 32'h1000 + 32'(i * 16), 32'h40, 1'b0, 32'h0);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput("bp_fill");
        end
        checkValue("bp.in_ready_low", 32'(in_ready), 32'd0);
        checkValue("bp.head_pc", out_redirect_pc, 32'h1040);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
            checkOutput("bp_drain");
        end

        // Flush with both entries full and a new op offered.
        for (int i = 0; i < 2; i++) begin
            setOp(3'b000, 1'b0, 1'b0, 32'h7, 32'h7, 32'h2000 + 32'(i * 16), 32'h8, 1'b0, 32'h0);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput("fl_fill");
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("flush");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("flush_idle");

        // Saturation: 20 mispredicting branches from a fresh reset.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("sat_reset");
        for (int i = 0; i < 20; i++) begin
            setOp(3'b000, 1'b0, 1'b0, 32'h9, 32'h9, 32'h3000 + 32'(i * 4), 32'h20, 1'b0, 32'h0);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
            checkOutput("sat_run");
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkValue("sat.branch_const", 32'(branch_cnt), 32'hF);
        checkValue("sat.mispred_const", 32'(mispred_cnt), 32'hF);

        // Randomised traffic with backpressure, flushes and rare resets.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            r_op1 = $urandom();
            r_pc  = $urandom() & 32'hFFFF_FFFC;
            r_imm = ($urandom_range(0, 1) == 1) ? 32'($signed(12'($urandom()))) : $urandom();
            setOp(3'($urandom()),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 7) == 0),
                  r_op1,
                  ($urandom_range(0, 2) == 0) ? r_op1 : $urandom(),
                  r_pc, r_imm,
                  1'($urandom()),
                  ($urandom_range(0, 1) == 1) ? r_pc + r_imm : $urandom());
            r_rst   = ($urandom_range(0, 99) != 0);
            r_flush = ($urandom_range(0, 19) == 0);
            applyStimulus(r_rst, r_flush, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
            checkOutput("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised, pipelined successor to the combinational branch comparator.
- Evaluates RISC-V conditional branches and JAL/JALR, computes the target and checks it against the front-end prediction.
- Sits between execute and fetch-redirect logic behind a valid/ready handshake with a 2-entry skid buffer; keeps saturating branch and mispredict counters.

Parameters:
- XLEN, 32, operand/PC/target width (>= 8).
- CNT_W, 32, width of each performance counter.
- INST_BYTES, 4, fall-through increment added to PC for the not-taken path.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- flush_i  in  1  discard all held and incoming ops.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  unit can accept.
- in_func3  in  3  branch type (BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111).
- in_jal  in  1  unconditional PC-relative jump.
- in_jalr  in  1  unconditional register-indirect jump.
- in_op1, in_op2  in  XLEN  compare operands (op1 is the JALR base).
- in_pc, in_imm  in  XLEN  instruction PC, sign-extended offset.
- in_pred_taken  in  1  front-end predicted taken.
- in_pred_target  in  XLEN  front-end predicted target.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_taken  out  1  resolved direction.
- out_mispredict  out  1  redirect required.
- out_redirect_pc  out  XLEN  correct next PC.
- out_illegal  out  1  func3 010/011 on a non-jump op.
- branch_cnt  out  CNT_W  retired branch/jump count.
- mispred_cnt  out  CNT_W  retired mispredict count.

Behaviour:
- Reset (rst_n low at posedge): both buffer entries invalid, out_valid=0, in_ready=1, all out_* data outputs 0, both counters 0.
- Condition evaluation: signed compare for BLT/BGE and unsigned for BLTU/BGEU at full XLEN. in_jal and in_jalr force taken=1. If both in_jal and in_jalr are set, in_jalr wins.
- Illegal func3 (010/011) with no jump: taken=0, illegal=1.
- Target arithmetic, modulo 2^XLEN (wrap-around, no carry-out):
  - jal/branch: pc+imm.
  - jalr: (op1+imm) with bit0 cleared.
  - fall-through: pc+INST_BYTES.
- mispredict = (taken != pred_taken) OR (taken AND pred_target != target).
- redirect_pc = taken ? target : pc+INST_BYTES. It is valid regardless of mispredict.
- Latency and throughput: accept on in_valid&&in_ready; result visible on out_valid exactly 1 cycle later when the output entry is empty. Full throughput of 1 op/cycle while out_ready=1.
- Skid buffer: output entry plus one skid entry.
  - in_ready = !skid_valid, registered.
  - If out_ready is low while an op is accepted into a full output entry, the op goes to the skid entry and in_ready drops next cycle.
  - When the output drains, skid moves to output and in_ready rises.
  - Order is strictly preserved. Outputs are stable while out_valid&&!out_ready.
- Flush: on the cycle flush_i=1, any in_valid op is dropped and both entries are invalidated at that edge. out_valid=0 and in_ready=1 next cycle. A handshake occurring in the flush cycle still counts.
- Counters update on out_valid&&out_ready only:
  - branch_cnt +1 unless illegal.
  - mispred_cnt +1 if mispredict and not illegal.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation: held ops are discarded, no counter update, reset values apply next cycle.
- No combinational path from in_* to out_*. out_ready does not affect in_ready combinationally.

Decomposition:
- Package branch_pkg:
  - func3 localparams (F3_BEQ … F3_BGEU).
  - Packed result struct {taken, mispredict, illegal, redirect_pc}, parametrised via XLEN in the instantiating module.
- Sub-module branch_cond_eval: parametrised (XLEN), purely combinational. Takes func3/op1/op2/jal/jalr and outputs taken and illegal. The top module owns target math, the skid buffer and the counters.

Test Plan:
- Operand compares (XLEN=32, out_ready=1):
  - BLT op1=0xFFFFFFFF, op2=1 -> taken=1.
  - BLTU same operands -> taken=0.
  - BGEU op1=op2=0x80000000 -> taken=1.
  - Each result appears exactly 1 cycle after accept.
- Predicted-path check: BEQ pc=0x100, imm=0x20, op1=op2, pred_taken=1, pred_target=0x124 -> taken=1, mispredict=1, redirect_pc=0x120. Repeat with pred_target=0x120 -> mispredict=0.
- JALR and wrap-around: op1=0x1001, imm=0x4 -> redirect_pc=0x1004. JAL with pc=0xFFFFFFF8, imm=0x10 -> redirect_pc=0x8.
- Backpressure: 3 back-to-back ops with out_ready=0 -> 2 held, in_ready=0 after the second accept. Release out_ready -> ops emerge in order, 1/cycle, with no loss or duplication.
- Flush and illegal ops:
  - Flush with both entries full and in_valid=1 -> out_valid=0 next cycle, counters unchanged.
  - func3=010 -> illegal=1, taken=0, branch_cnt unchanged.
- Counter saturation: CNT_W=4, retire 20 mispredicting branches -> branch_cnt=mispred_cnt=0xF, held there.
